// File: rtl/keccak_pad_feeder.sv
// SHA-3 multi-rate padding front-end: packs message words into Keccak rate blocks.
// Define KECCAK_PAD_SHAKE_EN to use the SHAKE domain byte (0x1F) instead of SHA3 (0x06).
module keccak_pad_feeder #(
   parameter int unsigned WIDTH      = 64,
   parameter int unsigned RATE_LANES = 17
) (
   input  logic                          clk,
   input  logic                          nrst,
   input  logic [WIDTH-1:0]              s_data,
   input  logic                          s_valid,
   input  logic                          s_last,
   input  logic [3:0]                    s_bytes,
   output logic                          s_ready,
   output logic [0:4][0:4][WIDTH-1:0]    blk_data,
   output logic                          blk_valid,
   output logic                          blk_last,
   input  logic                          blk_ready
);

   localparam int unsigned NLANES = 25;
   localparam int unsigned NBYTES = WIDTH / 8;

`ifdef KECCAK_PAD_SHAKE_EN
   localparam logic [7:0] DOMAIN_BYTE = 8'h1F;
`else
   localparam logic [7:0] DOMAIN_BYTE = 8'h06;
`endif

   localparam logic [WIDTH-1:0] PAD_START = WIDTH'(DOMAIN_BYTE);
   localparam logic [WIDTH-1:0] PAD_END   = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [4:0]       LAST_LANE = 5'(RATE_LANES - 1);

   typedef enum logic [1:0] {
      StFill,
      StPad,
      StSend
   } state_e;

   state_e                        state_q, state_d;
   logic [NLANES-1:0][WIDTH-1:0]  lane_q, lane_d;
   logic [4:0]                    lane_cnt_q, lane_cnt_d;
   logic [4:0]                    last_lane_q, last_lane_d;
   logic [3:0]                    last_bytes_q, last_bytes_d;
   logic                          extra_pend_q, extra_pend_d;
   logic                          blk_valid_q, blk_valid_d;
   logic                          blk_last_q, blk_last_d;

   logic [3:0]                    s_bytes_sat;
   logic [WIDTH-1:0]              in_word;
   logic                          pad_full;
   logic                          pad_fits;
   logic [4:0]                    pad_lane;
   logic [WIDTH-1:0]              pad_word;

   assign s_bytes_sat = (s_bytes > 4'd8) ? 4'd8 : s_bytes;

   // Final word keeps only its valid low-order bytes.
   always_comb begin
      in_word = s_data;
      if (s_last) begin
         for (int b = 0; b < int'(NBYTES); b++) begin
            if (b >= int'(s_bytes_sat)) begin
               in_word[8*b +: 8] = '0;
            end
         end
      end
   end

   // A full final word pushes the pad start into the next lane; when that lane is
   // beyond the rate, the padding needs a block of its own.
   assign pad_full = (last_bytes_q == 4'd8);
   assign pad_lane = last_lane_q + {4'b0, pad_full};
   assign pad_fits = !(pad_full && (last_lane_q == LAST_LANE));
   assign pad_word = PAD_START << {last_bytes_q[2:0], 3'b000};

   always_comb begin
      state_d      = state_q;
      lane_d       = lane_q;
      lane_cnt_d   = lane_cnt_q;
      last_lane_d  = last_lane_q;
      last_bytes_d = last_bytes_q;
      extra_pend_d = extra_pend_q;
      blk_valid_d  = blk_valid_q;
      blk_last_d   = blk_last_q;

      unique case (state_q)
         StFill: begin
            if (s_valid) begin
               lane_d[lane_cnt_q] = in_word;
               if (s_last) begin
                  last_lane_d  = lane_cnt_q;
                  last_bytes_d = s_bytes_sat;
                  state_d      = StPad;
               end else if (lane_cnt_q == LAST_LANE) begin
                  blk_valid_d = 1'b1;
                  blk_last_d  = 1'b0;
                  state_d     = StSend;
               end else begin
                  lane_cnt_d = lane_cnt_q + 5'd1;
               end
            end
         end

         StPad: begin
            blk_valid_d = 1'b1;
            state_d     = StSend;
            if (pad_fits) begin
               for (int k = 0; k < int'(NLANES); k++) begin
                  if (k > int'(last_lane_q)) begin
                     lane_d[k] = '0;
                  end
               end
               lane_d[pad_lane]  = lane_d[pad_lane] ^ pad_word;
               lane_d[LAST_LANE] = lane_d[LAST_LANE] ^ PAD_END;
               blk_last_d        = 1'b1;
            end else begin
               extra_pend_d = 1'b1;
               blk_last_d   = 1'b0;
            end
         end

         StSend: begin
            if (blk_ready) begin
               lane_d = '0;
               if (extra_pend_q) begin
                  lane_d[0]         = PAD_START;
                  lane_d[LAST_LANE] = lane_d[LAST_LANE] ^ PAD_END;
                  blk_last_d        = 1'b1;
                  extra_pend_d      = 1'b0;
               end else begin
                  blk_valid_d = 1'b0;
                  blk_last_d  = 1'b0;
                  lane_cnt_d  = '0;
                  state_d     = StFill;
               end
            end
         end

         default: begin
            state_d = StFill;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= StFill;
         lane_q       <= '0;
         lane_cnt_q   <= '0;
         last_lane_q  <= '0;
         last_bytes_q <= '0;
         extra_pend_q <= 1'b0;
         blk_valid_q  <= 1'b0;
         blk_last_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         lane_q       <= lane_d;
         lane_cnt_q   <= lane_cnt_d;
         last_lane_q  <= last_lane_d;
         last_bytes_q <= last_bytes_d;
         extra_pend_q <= extra_pend_d;
         blk_valid_q  <= blk_valid_d;
         blk_last_q   <= blk_last_d;
      end
   end

   always_comb begin
      for (int x = 0; x < 5; x++) begin
         for (int y = 0; y < 5; y++) begin
            blk_data[x][y] = lane_q[x + 5*y];
         end
      end
   end

   assign s_ready   = (state_q == StFill);
   assign blk_valid = blk_valid_q;
   assign blk_last  = blk_last_q;

endmodule

// File: tb/tb_keccak_pad_feeder.sv
// Directed self-checking bench for keccak_pad_feeder (SHA3-256 rate, SHA3 domain byte).
module tb_keccak_pad_feeder;

   localparam int unsigned W = 64;
   localparam int unsigned R = 17;

   logic                       clk = 1'b0;
   logic                       nrst;
   logic [W-1:0]               s_data;
   logic                       s_valid;
   logic                       s_last;
   logic [3:0]                 s_bytes;
   logic                       s_ready;
   logic [0:4][0:4][W-1:0]     blk_data;
   logic                       blk_valid;
   logic                       blk_last;
   logic                       blk_ready;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_l [25];
   logic [63:0] held_lane0;

   keccak_pad_feeder #(.WIDTH(W), .RATE_LANES(R)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_last    (s_last),
      .s_bytes   (s_bytes),
      .s_ready   (s_ready),
      .blk_data  (blk_data),
      .blk_valid (blk_valid),
      .blk_last  (blk_last),
      .blk_ready (blk_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] lane_of(input int k);
      return blk_data[k % 5][k / 5];
   endfunction

   function automatic logic [63:0] word_of(input int i);
      return 64'h0101_0101_0101_0101 * 64'(i + 1);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_exp();
      for (int k = 0; k < 25; k++) exp_l[k] = '0;
   endtask

   task automatic check_block(input string tag, input logic exp_last);
      check({tag, " blk_valid"}, 64'(blk_valid), 64'(1'b1));
      check({tag, " blk_last"}, 64'(blk_last), 64'(exp_last));
      for (int k = 0; k < 25; k++) begin
         check($sformatf("%s lane%0d", tag, k), lane_of(k), exp_l[k]);
      end
   endtask

   // Drives one word and returns #1 after the edge that accepted it.
   task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
      int n;
      s_data  = d;
      s_last  = last;
      s_bytes = nb;
      s_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (s_ready) break;
         n++;
         if (n > 20) begin
            checks++;
            errors++;
            $error("FAIL s_ready timeout: observed 0 expected 1");
            break;
         end
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_bytes = '0;
      s_data  = '0;
   endtask

   task automatic take_blk();
      blk_ready = 1'b1;
      @(posedge clk);
      #1;
      blk_ready = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      nrst      = 1'b0;
      s_data    = '0;
      s_valid   = 1'b0;
      s_last    = 1'b0;
      s_bytes   = '0;
      blk_ready = 1'b0;
      #12;
      check("reset s_ready", 64'(s_ready), 64'd1);
      check("reset blk_valid", 64'(blk_valid), 64'd0);
      check("reset blk_last", 64'(blk_last), 64'd0);
      check("reset lane0", lane_of(0), 64'd0);
      @(negedge clk);
      nrst = 1'b1;
      step();

      // Empty message; data bits must be ignored.
      send_word(64'hDEAD_BEEF_CAFE_F00D, 1'b1, 4'd0);
      check("empty pad cycle blk_valid", 64'(blk_valid), 64'd0);
      check("empty pad cycle s_ready", 64'(s_ready), 64'd0);
      step();
      clear_exp();
      exp_l[0]  = 64'h0000_0000_0000_0006;
      exp_l[16] = 64'h8000_0000_0000_0000;
      check_block("empty", 1'b1);
      take_blk();
      check("empty after blk_valid", 64'(blk_valid), 64'd0);
      check("empty after s_ready", 64'(s_ready), 64'd1);
      check("empty after lane0", lane_of(0), 64'd0);

      // "abc" with junk above the valid bytes, then backpressure.
      send_word(64'hFFFF_FFFF_FF63_6261, 1'b1, 4'd3);
      check("abc t+1 blk_valid", 64'(blk_valid), 64'd0);
      step();
      clear_exp();
      exp_l[0]  = 64'h0000_0000_0663_6261;
      exp_l[16] = 64'h8000_0000_0000_0000;
      check_block("abc", 1'b1);
      held_lane0 = lane_of(0);
      for (int c = 0; c < 5; c++) begin
         step();
         check($sformatf("bp%0d blk_valid", c), 64'(blk_valid), 64'd1);
         check($sformatf("bp%0d blk_last", c), 64'(blk_last), 64'd1);
         check($sformatf("bp%0d lane0", c), lane_of(0), held_lane0);
         check($sformatf("bp%0d s_ready", c), 64'(s_ready), 64'd0);
      end
      take_blk();
      check("bp after blk_valid", 64'(blk_valid), 64'd0);
      check("bp after s_ready", 64'(s_ready), 64'd1);

      // 135 bytes: pad start and end share the last rate byte.
      for (int i = 0; i < 16; i++) send_word(64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 4'd0);
      send_word(64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 4'd7);
      step();
      clear_exp();
      for (int k = 0; k < 16; k++) exp_l[k] = 64'hAAAA_AAAA_AAAA_AAAA;
      exp_l[16] = 64'h86AA_AAAA_AAAA_AAAA;
      check_block("b135", 1'b1);
      take_blk();

      // 136 bytes: exact fill needs a padding-only second block.
      for (int i = 0; i < 17; i++) send_word(word_of(i), (i == 16), (i == 16) ? 4'd8 : 4'd0);
      check("b136 pad s_ready", 64'(s_ready), 64'd0);
      step();
      clear_exp();
      for (int k = 0; k < 17; k++) exp_l[k] = word_of(k);
      check_block("b136 blk1", 1'b0);
      check("b136 blk1 s_ready", 64'(s_ready), 64'd0);
      take_blk();
      clear_exp();
      exp_l[0]  = 64'h0000_0000_0000_0006;
      exp_l[16] = 64'h8000_0000_0000_0000;
      check_block("b136 blk2", 1'b1);
      check("b136 blk2 s_ready", 64'(s_ready), 64'd0);
      take_blk();
      check("b136 done blk_valid", 64'(blk_valid), 64'd0);
      check("b136 done s_ready", 64'(s_ready), 64'd1);

      // Full non-last block appears one cycle after its final word.
      for (int i = 0; i < 17; i++) send_word(word_of(i + 3), 1'b0, 4'd0);
      clear_exp();
      for (int k = 0; k < 17; k++) exp_l[k] = word_of(k + 3);
      check_block("full", 1'b0);
      take_blk();
      // s_bytes above 8 clamps to 8: pad start moves to lane 1.
      send_word(64'h1122_3344_5566_7788, 1'b1, 4'd15);
      step();
      clear_exp();
      exp_l[0]  = 64'h1122_3344_5566_7788;
      exp_l[1]  = 64'h0000_0000_0000_0006;
      exp_l[16] = 64'h8000_0000_0000_0000;
      check_block("clamp", 1'b1);
      take_blk();

      // Reset mid-message discards partial data.
      for (int i = 0; i < 5; i++) send_word(word_of(i + 40), 1'b0, 4'd0);
      nrst = 1'b0;
      #1;
      check("rst s_ready", 64'(s_ready), 64'd1);
      check("rst blk_valid", 64'(blk_valid), 64'd0);
      check("rst blk_last", 64'(blk_last), 64'd0);
      for (int k = 0; k < 5; k++) check($sformatf("rst lane%0d", k), lane_of(k), 64'd0);
      @(negedge clk);
      nrst = 1'b1;
      step();
      send_word(64'h0000_0000_0063_6261, 1'b1, 4'd3);
      step();
      clear_exp();
      exp_l[0]  = 64'h0000_0000_0663_6261;
      exp_l[16] = 64'h8000_0000_0000_0000;
      check_block("post-rst abc", 1'b1);
      take_blk();
      check("post-rst s_ready", 64'(s_ready), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/keccak_pad_feeder.md
Name: keccak_pad_feeder

Overview:
Front-end transmitter for the Keccak absorb core. It accepts a message as a stream of WIDTH-bit words and applies SHA-3 multi-rate padding. It packs the words into rate-sized blocks laid out as the core's 5x5 lane array, with capacity lanes zeroed. It presents each block with a valid/last/ready handshake that drives the core's Din, Din_valid and Last_block inputs.

Parameters:
- WIDTH, 64, lane width in bits; fixed at 64 for SHA-3.
- RATE_LANES, 17, lanes per block: 17 for SHA3-256, 9 for SHA3-512, 21 for SHAKE128. Legal range 1..24.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, asynchronous, active-low.
- s_data  in  WIDTH  message word, little-endian: byte i at bits 8i+7:8i.
- s_valid  in  1  s_data valid.
- s_last  in  1  final message word.
- s_bytes  in  4  valid bytes in the final word, 0..8; ignored unless s_last.
- s_ready  out  1  feeder accepts a word this cycle.
- blk_data  out  [0:4][0:4][WIDTH-1:0]  block; lane k at index [k mod 5][k div 5].
- blk_valid  out  1  block valid; connects to core Din_valid.
- blk_last  out  1  final padded block; connects to core Last_block.
- blk_ready  in  1  core accepts the block this cycle.

Behaviour:
- Reset (async, nrst low): state FILL, lane_cnt=0, blk_data=0, blk_valid=0, blk_last=0, s_ready=1, extra_pend=0. Reset mid-block discards all partial data.
- A word transfers on s_valid&&s_ready. A block transfers on blk_valid&&blk_ready.
- FILL:
  - s_ready=1. Each accepted word is written to lane lane_cnt, then lane_cnt increments.
  - Non-last word filling lane RATE_LANES-1: block complete, go to SEND with blk_last=0.
  - Last word: keep bytes 0..s_bytes-1, zero the other bytes, then go to PAD.
- PAD, one cycle, s_ready=0:
  - Pad position p = 8*L + s_bytes, where L is the lane index of the last word.
  - If p < 8*RATE_LANES: XOR 0x06 into byte p, zero all lanes above L, XOR 0x80 into byte 7 of lane RATE_LANES-1. This gives 0x86 when p is that same byte. Set blk_last=1, go to SEND.
  - Else (last word filled the block exactly): set extra_pend=1, send the current block with blk_last=0, go to SEND.
- SEND:
  - s_ready=0. blk_valid=1. blk_data and blk_last held stable until blk_ready.
  - On transfer with extra_pend=1: load the padding-only block (lane0=0x06, lane RATE_LANES-1 bit 63 set, all other lanes 0), set blk_last=1, clear extra_pend, stay in SEND.
  - Otherwise on transfer: blk_valid=0, blk_last=0, clear blk_data, lane_cnt=0, go to FILL. s_ready rises the following cycle.
- Empty message: s_last with s_bytes=0 as the first word gives a single block with lane0=0x06, lane RATE_LANES-1=0x8000_0000_0000_0000.
- s_bytes > 8 is treated as 8.
- Capacity lanes RATE_LANES..24 are always 0.
- Latency: last word accepted at cycle t gives blk_valid high at t+2 (through PAD). A full non-last block gives blk_valid at t+1.
- blk_valid never drops without a transfer. blk_ready while blk_valid=0 is ignored.

Optional Feature:
KECCAK_PAD_SHAKE_EN
- Defined: domain/pad-start byte is 0x1F (SHAKE XOF); the padding-only block's lane0 = 0x1F; the shared-byte case yields 0x9F.
- Undefined: byte is 0x06 (SHA3 hash); shared case 0x86.

Test Plan:
- Empty message (s_last=1, s_bytes=0, data ignored) -> one block, lane0=0x0000_0000_0000_0006, lane16=0x8000_0000_0000_0000, other lanes 0, blk_last=1.
- "abc" (s_data=0x636261, s_bytes=3, s_last=1) -> lane0=0x0000_0000_0663_6261, lane16=0x8000_0000_0000_0000, blk_last=1, blk_valid two cycles after acceptance.
- 135 bytes (16 full words, then last word s_bytes=7 with bytes 0xAA) -> one block, lane16=0x86AA_AAAA_AAAA_AAAA, blk_last=1.
- 136 bytes (17 full words, last with s_bytes=8) -> block 1 data-only, blk_last=0; then block 2 with lane0=0x06, lane16=0x8000_0000_0000_0000, blk_last=1; s_ready low throughout.
- Backpressure: hold blk_ready=0 for 5 cycles in SEND -> blk_valid, blk_data and blk_last stable, s_ready=0; transfer on cycle 6, s_ready=1 on cycle 7.
- Pulse nrst low after 5 words of a message -> outputs return to reset values immediately; a new "abc" message then produces exactly the "abc" block above.
